// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel path: line geometry, pixel width and
// the line-buffer write-state encoding.
package vga_pkg;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned PTR_W    = 10;
  localparam int unsigned RGB_W    = 3;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } wrState_t;
endpackage

// File: rtl/vga_line_ram.sv
// Two-bank pixel store: simple dual-port RAM, synchronous write, registered
// read, addressed as {bank, ptr} so it maps onto a single block RAM.
module vga_line_ram #(
  parameter int unsigned PTR_W = vga_pkg::PTR_W
) (
  input  logic                      clk,
  input  logic                      wrEn,
  input  logic [PTR_W:0]            wrAddr,
  input  logic [vga_pkg::RGB_W-1:0] wrData,
  input  logic [PTR_W:0]            rdAddr,
  output logic [vga_pkg::RGB_W-1:0] rdData
);
  import vga_pkg::*;

  localparam int unsigned DEPTH = 2 ** (PTR_W + 1);

  logic [RGB_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end
endmodule

// File: rtl/vga_line_buffer.sv
// Double-buffered RGB line store: the producer fills the back bank while the
// front bank is scanned out; banks swap on line_start once the back is full.
module vga_line_buffer #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned PTR_W    = vga_pkg::PTR_W
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       line_start,
  input  logic       pix_en,
  input  logic       wr_valid,
  input  logic [2:0] wr_data,
  output logic       wr_ready,
  output logic       line_req,
  output logic       r,
  output logic       g,
  output logic       b,
  output logic       underrun
);
  import vga_pkg::*;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(H_ACTIVE - 1);
  localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(H_ACTIVE);

  wrState_t         state;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             bankSel;
  logic             frontValid;
  logic             pixValid;
  logic             lineReqQ;
  logic             underrunQ;
  logic             accept;
  logic             complete;
  logic             swap;
  logic             readEn;
  logic [RGB_W-1:0] ramData;

  assign wr_ready = !Reset && (state == FILL);
  assign accept   = wr_valid && wr_ready;
  // A write accepted in the line_start cycle may itself complete the bank.
  assign complete = (state == FULL) || (accept && (wrPtr == PTR_LAST));
  assign swap     = line_start && complete;
  assign readEn   = pix_en && !line_start && (rdPtr < PTR_END) && frontValid;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= FILL;
      wrPtr      <= '0;
      rdPtr      <= PTR_END;
      bankSel    <= 1'b0;
      frontValid <= 1'b0;
      pixValid   <= 1'b0;
      lineReqQ   <= 1'b1;
      underrunQ  <= 1'b0;
    end else begin
      pixValid  <= readEn;
      lineReqQ  <= swap;
      underrunQ <= line_start && !complete;

      if (swap) begin
        bankSel    <= ~bankSel;
        frontValid <= 1'b1;
        wrPtr      <= '0;
        state      <= FILL;
      end else if (accept) begin
        wrPtr <= wrPtr + 1'b1;
        if (wrPtr == PTR_LAST) state <= FULL;
      end

      if (line_start)  rdPtr <= '0;
      else if (readEn) rdPtr <= rdPtr + 1'b1;
    end
  end

  vga_line_ram #(.PTR_W(PTR_W)) u_ram (
    .clk    (clk),
    .wrEn   (accept),
    .wrAddr ({~bankSel, wrPtr}),
    .wrData (wr_data),
    .rdAddr ({bankSel, rdPtr}),
    .rdData (ramData)
  );

  // line_req is held in its flop during reset so it shows on the first free cycle.
  assign line_req    = lineReqQ && !Reset;
  assign underrun    = underrunQ;
  assign {r, g, b}   = pixValid ? ramData : '0;
endmodule

// File: tb/tb_vga_line_buffer.sv
// Self-checking bench for vga_line_buffer with an 8-pixel line, compared
// against a line-level model (arrays of whole lines and a fill count).
module tb_vga_line_buffer;
  localparam int H = 8;

  typedef struct packed {
    logic       rst;
    logic       ls;
    logic       pe;
    logic       wv;
    logic [2:0] wd;
  } vec_t;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       line_start = 1'b0;
  logic       pix_en = 1'b0;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_data = '0;
  logic       wr_ready, line_req, r, g, b, underrun;

  int nChecks = 0;
  int nErrors = 0;

  // Line-level reference model
  logic [2:0] backBuf  [H];
  logic [2:0] frontBuf [H];
  int         backCount = 0;
  int         ridx = H;
  bit         fv = 1'b0;
  bit         lrFlag = 1'b1;
  logic [2:0] expRgb = '0;
  bit         expUnd = 1'b0;
  bit         expWrReady, expLineReq;

  vec_t stim[$];

  vga_line_buffer #(.H_ACTIVE(H), .PTR_W(4)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .line_start (line_start),
    .pix_en     (pix_en),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .line_req   (line_req),
    .r          (r),
    .g          (g),
    .b          (b),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic drive(input vec_t v);
    Reset      = v.rst;
    line_start = v.ls;
    pix_en     = v.pe;
    wr_valid   = v.wv;
    wr_data    = v.wd;
    @(negedge clk);
    expWrReady = !v.rst && (backCount < H);
    expLineReq = lrFlag && !v.rst;
  endtask

  task automatic tick();
    @(posedge clk);
    if (Reset) begin
      backCount = 0; fv = 1'b0; ridx = H; expRgb = '0; expUnd = 1'b0; lrFlag = 1'b1;
    end else begin
      if (wr_valid && backCount < H) begin
        backBuf[backCount] = wr_data;
        backCount++;
      end
      if (pix_en && !line_start && ridx < H && fv) begin
        expRgb = frontBuf[ridx];
        ridx++;
      end else expRgb = '0;
      lrFlag = 1'b0; expUnd = 1'b0;
      if (line_start) begin
        ridx = 0;
        if (backCount == H) begin
          frontBuf = backBuf; fv = 1'b1; backCount = 0; lrFlag = 1'b1;
        end else expUnd = 1'b1;
      end
    end
    #1;
  endtask

  function automatic vec_t mk(bit rst, bit ls, bit pe, bit wv, logic [2:0] wd);
    vec_t v;
    v.rst = rst; v.ls = ls; v.pe = pe; v.wv = wv; v.wd = wd;
    return v;
  endfunction

  function automatic void push_writes(int n, bit gaps);
    int k = 0;
    while (k < n) begin
      if (gaps && $urandom_range(0, 2) == 0) stim.push_back(mk(0, 0, 0, 0, 3'($urandom)));
      else begin
        stim.push_back(mk(0, 0, 0, 1, 3'($urandom)));
        k++;
      end
    end
  endfunction

  function automatic void push_line(int npe);
    stim.push_back(mk(0, 1, 0, 0, '0));
    for (int i = 0; i < npe; i++) stim.push_back(mk(0, 0, 1, 0, '0));
    stim.push_back(mk(0, 0, 0, 0, '0));
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(mk(1, 0, 0, 1, 3'd7));
      nChecks++; if ({r, g, b} !== 3'd0) begin nErrors++; $display("FAIL reset_rgb[%0d]: got %0d want 0", i, {r, g, b}); end
      nChecks++; if (wr_ready !== 1'b0) begin nErrors++; $display("FAIL reset_wr_ready[%0d]: got %b want 0", i, wr_ready); end
      nChecks++; if (underrun !== 1'b0) begin nErrors++; $display("FAIL reset_underrun[%0d]: got %b want 0", i, underrun); end
      tick();
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i <= H; i++) begin
      drive(mk(0, 0, 0, 1, (i < H) ? 3'(i) : 3'd5));
      nChecks++; if (line_req !== expLineReq) begin nErrors++; $display("FAIL fill_line_req[%0d]: got %b want %b", i, line_req, expLineReq); end
      nChecks++; if (wr_ready !== expWrReady) begin nErrors++; $display("FAIL fill_wr_ready[%0d]: got %b want %b", i, wr_ready, expWrReady); end
      tick();
    end
  endtask

  task automatic test_swap_read();
    stim.delete();
    push_line(H);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i]);
      nChecks++; if ({r, g, b} !== expRgb) begin nErrors++; $display("FAIL swap_rgb[%0d]: got %0d want %0d", i, {r, g, b}, expRgb); end
      nChecks++; if (line_req !== expLineReq) begin nErrors++; $display("FAIL swap_line_req[%0d]: got %b want %b", i, line_req, expLineReq); end
      nChecks++; if (underrun !== expUnd) begin nErrors++; $display("FAIL swap_underrun[%0d]: got %b want %b", i, underrun, expUnd); end
      tick();
    end
  endtask

  task automatic test_underrun();
    stim.delete();
    push_writes(5, 1'b1);
    push_line(H);
    push_writes(3, 1'b1);
    push_line(H);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i]);
      nChecks++; if ({r, g, b} !== expRgb) begin nErrors++; $display("FAIL under_rgb[%0d]: got %0d want %0d", i, {r, g, b}, expRgb); end
      nChecks++; if (underrun !== expUnd) begin nErrors++; $display("FAIL under_underrun[%0d]: got %b want %b", i, underrun, expUnd); end
      nChecks++; if (line_req !== expLineReq) begin nErrors++; $display("FAIL under_line_req[%0d]: got %b want %b", i, line_req, expLineReq); end
      nChecks++; if (wr_ready !== expWrReady) begin nErrors++; $display("FAIL under_wr_ready[%0d]: got %b want %b", i, wr_ready, expWrReady); end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    stim.delete();
    push_writes(H - 1, 1'b0);
    stim.push_back(mk(0, 1, 0, 1, 3'($urandom)));
    for (int i = 0; i < H; i++) stim.push_back(mk(0, 0, 1, 0, '0));
    stim.push_back(mk(0, 0, 0, 0, '0));
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i]);
      nChecks++; if ({r, g, b} !== expRgb) begin nErrors++; $display("FAIL simul_rgb[%0d]: got %0d want %0d", i, {r, g, b}, expRgb); end
      nChecks++; if (underrun !== expUnd) begin nErrors++; $display("FAIL simul_underrun[%0d]: got %b want %b", i, underrun, expUnd); end
      nChecks++; if (line_req !== expLineReq) begin nErrors++; $display("FAIL simul_line_req[%0d]: got %b want %b", i, line_req, expLineReq); end
      tick();
    end
  endtask

  task automatic test_overrun();
    stim.delete();
    push_writes(H, 1'b1);
    push_line(H + 3);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i]);
      nChecks++; if ({r, g, b} !== expRgb) begin nErrors++; $display("FAIL over_rgb[%0d]: got %0d want %0d", i, {r, g, b}, expRgb); end
      nChecks++; if (wr_ready !== expWrReady) begin nErrors++; $display("FAIL over_wr_ready[%0d]: got %b want %b", i, wr_ready, expWrReady); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    stim.delete();
    push_writes(H, 1'b0);
    stim.push_back(mk(0, 1, 0, 0, '0));
    for (int i = 0; i < 3; i++) stim.push_back(mk(0, 0, 1, 1, 3'($urandom)));
    stim.push_back(mk(1, 0, 1, 1, 3'($urandom)));
    stim.push_back(mk(1, 1, 1, 1, 3'($urandom)));
    push_line(H);
    push_writes(H, 1'b1);
    push_line(H);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i]);
      nChecks++; if ({r, g, b} !== expRgb) begin nErrors++; $display("FAIL rstmid_rgb[%0d]: got %0d want %0d", i, {r, g, b}, expRgb); end
      nChecks++; if (underrun !== expUnd) begin nErrors++; $display("FAIL rstmid_underrun[%0d]: got %b want %b", i, underrun, expUnd); end
      nChecks++; if (line_req !== expLineReq) begin nErrors++; $display("FAIL rstmid_line_req[%0d]: got %b want %b", i, line_req, expLineReq); end
      nChecks++; if (wr_ready !== expWrReady) begin nErrors++; $display("FAIL rstmid_wr_ready[%0d]: got %b want %b", i, wr_ready, expWrReady); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_swap_read();
    test_underrun();
    test_simultaneous();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
